// File: rtl/ws2812_frame_sequencer.sv
// Double-buffered frame sequencer feeding a single-pixel WS2812B driver, one pixel per latch pulse.
// drv_rgb is registered and valid from the first STREAM cycle; pixels advance only on the driver's latch.
module ws2812_frame_sequencer #(
    parameter int NUM_LEDS       = 8,
    parameter int AW             = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    parameter int REFRESH_CYCLES = 270_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          commit,
    input  logic          start,
    input  logic [7:0]    brightness,
    output logic          drv_ready,
    output logic [23:0]   drv_rgb,
    input  logic          drv_busy,
    input  logic          drv_latched,
    output logic          frame_busy,
    output logic          frame_done,
    output logic          commit_pending
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [23:0]   r_shadow [NUM_LEDS];
    logic [23:0]   r_active [NUM_LEDS];
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic [7:0]    r_bri;
    logic [7:0]    w_bri_nxt;
    logic [23:0]   w_pix_nxt;
    logic [23:0]   r_rgb;
    logic [RW-1:0] r_ref_cnt;
    logic          w_ref_hit;
    logic          w_wr_ok;
    logic          w_last_lat;
    logic          r_start_pend;
    logic          r_commit_pend;
    logic          r_done;

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return 8'(p >> 8);
    endfunction

    assign w_wr_ok    = wr_en && (int'(wr_addr) < NUM_LEDS);
    assign w_ref_hit  = (REFRESH_CYCLES != 0) && (r_ref_cnt == REF_LAST);
    assign w_last_lat = (r_state == S_STREAM) && drv_latched && (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_start_pend && !drv_busy) w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_STREAM;
            S_STREAM: if (w_last_lat) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (!drv_busy) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        drv_ready  = (r_state == S_STREAM);
        frame_busy = (r_state != S_IDLE);
    end

    // The pixel for the next cycle is chosen from the post-edge view so the first
    // STREAM cycle already shows the freshly committed pixel 0 at the new brightness.
    always_comb begin
        w_idx_nxt = r_idx;
        if (r_state == S_LOAD)
            w_idx_nxt = '0;
        else if (r_state == S_STREAM && drv_latched && !w_last_lat)
            w_idx_nxt = r_idx + 1'b1;
        w_bri_nxt = (r_state == S_LOAD) ? brightness : r_bri;
        w_pix_nxt = (r_state == S_LOAD && r_commit_pend) ? r_shadow[w_idx_nxt]
                                                          : r_active[w_idx_nxt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_idx         <= '0;
            r_bri         <= 8'hFF;
            r_rgb         <= '0;
            r_ref_cnt     <= '0;
            r_start_pend  <= 1'b0;
            r_commit_pend <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (w_wr_ok)
                r_shadow[wr_addr] <= wr_data;
            if (r_state == S_LOAD && r_commit_pend)
                for (int i = 0; i < NUM_LEDS; i++)
                    r_active[i] <= r_shadow[i];
            r_idx         <= w_idx_nxt;
            r_bri         <= w_bri_nxt;
            r_commit_pend <= commit | (r_commit_pend & (r_state != S_LOAD));
            r_start_pend  <= start | w_ref_hit | (r_start_pend & (r_state != S_LOAD));
            r_ref_cnt     <= w_ref_hit ? '0 : r_ref_cnt + 1'b1;
            r_done        <= (r_state == S_DRAIN) && !drv_busy;
            r_rgb         <= (w_state_nxt == S_STREAM) ?
                             {scale8(w_pix_nxt[23:16], w_bri_nxt),
                              scale8(w_pix_nxt[15:8],  w_bri_nxt),
                              scale8(w_pix_nxt[7:0],   w_bri_nxt)} : 24'd0;
        end
    end

    assign drv_rgb        = r_rgb;
    assign frame_done     = r_done;
    assign commit_pending = r_commit_pend;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer with a behavioural WS2812 driver responder.
module tb_ws2812_frame_sequencer;

    localparam int BITS = 8;

    logic        clk = 1'b0;
    logic        rst, rst_r;
    logic        wr_en, commit, start;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  brightness;
    logic        drv_ready, drv_busy, drv_latched;
    logic [23:0] drv_rgb;
    logic        frame_busy, frame_done, commit_pending;

    logic        r_ready, r_lat, r_fbusy, r_done, r_cpend, r_prev;
    logic [23:0] r_rgb;

    int          errors = 0;
    int          checks = 0;
    int          n_lat = 0;
    int          done_cnt = 0;
    int          bcnt = 0;
    int          cyc = 0;
    int          nr = 0;
    logic [23:0] cap [64];
    logic        rdy_after [64];
    int          rises [8];

    always #5 clk = ~clk;

    ws2812_frame_sequencer #(.NUM_LEDS(3), .REFRESH_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .start(start), .brightness(brightness),
        .drv_ready(drv_ready), .drv_rgb(drv_rgb), .drv_busy(drv_busy),
        .drv_latched(drv_latched), .frame_busy(frame_busy), .frame_done(frame_done),
        .commit_pending(commit_pending)
    );

    ws2812_frame_sequencer #(.NUM_LEDS(3), .REFRESH_CYCLES(1000)) dut_r (
        .clk(clk), .rst(rst_r), .wr_en(1'b0), .wr_addr(2'd0), .wr_data(24'd0),
        .commit(1'b0), .start(1'b0), .brightness(8'hFF),
        .drv_ready(r_ready), .drv_rgb(r_rgb), .drv_busy(1'b0),
        .drv_latched(r_lat), .frame_busy(r_fbusy), .frame_done(r_done),
        .commit_pending(r_cpend)
    );

    // Driver model: latch when ready and idle, stay busy for BITS cycles.
    always @(negedge clk) begin
        if (rst) begin
            drv_latched = 1'b0;
            drv_busy    = 1'b0;
            bcnt        = 0;
        end else begin
            if (drv_latched) begin
                if (n_lat > 0 && n_lat <= 64) rdy_after[n_lat-1] = drv_ready;
                drv_latched = 1'b0;
            end
            if (frame_done) done_cnt++;
            if (bcnt != 0) begin
                bcnt--;
                if (bcnt == 0) drv_busy = 1'b0;
            end else if (drv_ready && !drv_busy) begin
                if (n_lat < 64) cap[n_lat] = drv_rgb;
                n_lat++;
                drv_latched = 1'b1;
                drv_busy    = 1'b1;
                bcnt        = BITS;
            end
        end
    end

    // Responder for the auto-refresh instance: always idle, latches whenever offered.
    always @(negedge clk) begin
        cyc++;
        if (rst_r) begin
            r_lat  = 1'b0;
            r_prev = 1'b0;
        end else begin
            r_lat = r_ready && !r_lat;
            if (r_fbusy && !r_prev && nr < 8) begin
                rises[nr] = cyc;
                nr++;
            end
            r_prev = r_fbusy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (done_cnt < target && k < 2000) begin
            step();
            k++;
        end
        chk(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_lat(input int target, input string tag);
        int k = 0;
        while (n_lat < target && k < 2000) begin
            step();
            k++;
        end
        chk(tag, 32'(n_lat >= target), 32'd1);
    endtask

    initial begin
        rst = 1'b1; rst_r = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; start = 1'b0; brightness = 8'hFF;
        repeat (3) step();
        chk("rst_ready", 32'(drv_ready), 32'd0);
        chk("rst_rgb", 32'(drv_rgb), 32'd0);
        chk("rst_fbusy", 32'(frame_busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_cpend", 32'(commit_pending), 32'd0);
        rst = 1'b0; rst_r = 1'b0;
        step();

        // Basic frame: three primaries at full brightness
        wr(2'd0, 24'hFF0000);
        wr(2'd1, 24'h00FF00);
        wr(2'd2, 24'h0000FF);
        pulse_commit();
        chk("t1_cpend_set", 32'(commit_pending), 32'd1);
        pulse_start();
        wait_done(1, "t1_done_to");
        chk("t1_nlat", 32'(n_lat), 32'd3);
        chk("t1_pix0", 32'(cap[0]), 32'hFF0000);
        chk("t1_pix1", 32'(cap[1]), 32'h00FF00);
        chk("t1_pix2", 32'(cap[2]), 32'h0000FF);
        chk("t1_rdy_after0", 32'(rdy_after[0]), 32'd1);
        chk("t1_rdy_after1", 32'(rdy_after[1]), 32'd1);
        chk("t1_rdy_after2", 32'(rdy_after[2]), 32'd0);
        chk("t1_cpend_clr", 32'(commit_pending), 32'd0);
        chk("t1_fbusy_idle", 32'(frame_busy), 32'd0);
        repeat (20) step();
        chk("t1_done_once", 32'(done_cnt), 32'd1);

        // Brightness scaling; brightness changed mid-frame must not take effect
        wr(2'd0, 24'h804020);
        pulse_commit();
        brightness = 8'h7F;
        pulse_start();
        repeat (12) step();
        brightness = 8'h00;
        wait_done(2, "t2_done_to");
        chk("t2_pix0", 32'(cap[3]), 32'h402010);
        chk("t2_pix1", 32'(cap[4]), 32'h007F00);
        chk("t2_pix2", 32'(cap[5]), 32'h00007F);
        pulse_start();
        wait_done(3, "t2b_done_to");
        chk("t2b_pix0", 32'(cap[6]), 32'h000000);
        chk("t2b_pix1", 32'(cap[7]), 32'h000000);
        chk("t2b_pix2", 32'(cap[8]), 32'h000000);

        // Shadow writes without commit leave the active table alone
        brightness = 8'hFF;
        wr(2'd0, 24'h111111);
        wr(2'd1, 24'h222222);
        wr(2'd2, 24'h333333);
        wr(2'd3, 24'hABCDEF);
        pulse_start();
        wait_done(4, "t3_done_to");
        chk("t3_old0", 32'(cap[9]), 32'h804020);
        chk("t3_old1", 32'(cap[10]), 32'h00FF00);
        chk("t3_old2", 32'(cap[11]), 32'h0000FF);
        chk("t3_cpend0", 32'(commit_pending), 32'd0);
        pulse_commit();
        chk("t3_cpend1", 32'(commit_pending), 32'd1);
        pulse_start();
        wait_done(5, "t3b_done_to");
        chk("t3_new0", 32'(cap[12]), 32'h111111);
        chk("t3_new1", 32'(cap[13]), 32'h222222);
        chk("t3_new2", 32'(cap[14]), 32'h333333);
        chk("t3_cpend2", 32'(commit_pending), 32'd0);

        // Starts during STREAM merge into exactly one extra frame
        pulse_start();
        wait_lat(16, "t4_lat_to");
        pulse_start();
        step();
        pulse_start();
        step();
        pulse_start();
        wait_done(7, "t4_done_to");
        repeat (150) step();
        chk("t4_done_cnt", 32'(done_cnt), 32'd7);
        chk("t4_nlat", 32'(n_lat), 32'd21);
        chk("t4_fbusy", 32'(frame_busy), 32'd0);

        // Reset in the middle of STREAM
        pulse_start();
        wait_lat(22, "t6_lat_to");
        repeat (3) step();
        chk("t6_pre_ready", 32'(drv_ready), 32'd1);
        chk("t6_pre_rgb", 32'(drv_rgb), 32'h222222);
        chk("t6_pre_fbusy", 32'(frame_busy), 32'd1);
        pulse_commit();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(drv_ready), 32'd0);
        chk("t6_rst_rgb", 32'(drv_rgb), 32'd0);
        chk("t6_rst_fbusy", 32'(frame_busy), 32'd0);
        chk("t6_rst_cpend", 32'(commit_pending), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        pulse_start();
        wait_done(8, "t6_done_to");
        chk("t6_act0", 32'(cap[22]), 32'h000000);
        chk("t6_act1", 32'(cap[23]), 32'h000000);
        chk("t6_act2", 32'(cap[24]), 32'h000000);
        pulse_commit();
        pulse_start();
        wait_done(9, "t6b_done_to");
        chk("t6_shd0", 32'(cap[25]), 32'h000000);
        chk("t6_shd2", 32'(cap[27]), 32'h000000);
        chk("t6_nlat", 32'(n_lat), 32'd28);

        // Auto-refresh instance: frames start every 1000 cycles; the REFRESH_CYCLES=0 instance stays idle
        begin
            int k = 0;
            while (nr < 3 && k < 5000) begin
                step();
                k++;
            end
        end
        chk("t5_rises", 32'(nr >= 3), 32'd1);
        chk("t5_period01", 32'(rises[1] - rises[0]), 32'd1000);
        chk("t5_period12", 32'(rises[2] - rises[1]), 32'd1000);
        chk("t5_no_refresh", 32'(done_cnt), 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
